// File: rtl/retire_unit.sv
// rtl/retire_unit.sv - in-order commit stage: retires the complete ROB head prefix, updates the arch map, frees Told
module retire_unit #(
    parameter int PR_W = 6,
    parameter int AR_N = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [2:0]                 rob_valid,
    input  logic [2:0]                 rob_complete,
    input  logic [2:0][4:0]            rob_ar,
    input  logic [2:0][PR_W-1:0]       rob_t,
    input  logic [2:0][PR_W-1:0]       rob_told,
    input  logic [2:0]                 rob_mispredict,
    input  logic [2:0]                 rob_halt,
    output logic [1:0]                 rob_pop,
    output logic [2:0]                 RetireEN,
    output logic [2:0][PR_W-1:0]       RetireReg,
    output logic                       BPRecoverEN,
    output logic [AR_N-1:0][PR_W-1:0]  arch_map,
    output logic                       halted
);

    typedef enum logic [1:0] {NORMAL, RECOVER, HALT} state_t;

    state_t                      state_q, state_d;
    logic [2:0]                  retire_en_q, retire_en_d;
    logic [2:0][PR_W-1:0]        retire_reg_q, retire_reg_d;
    logic                        bp_recover_q, bp_recover_d;
    logic                        halted_q, halted_d;
    logic [AR_N-1:0][PR_W-1:0]   arch_map_q, arch_map_d;
    logic [2:0]                  retire_mask;
    logic [2:0]                  stop_after;
    logic                        can_retire;

    // A mispredict or halt ends the prefix after itself; a gap ends it before itself.
    assign can_retire     = (state_q == NORMAL) && !reset;
    assign stop_after     = rob_mispredict | rob_halt;
    assign retire_mask[0] = can_retire & rob_valid[0] & rob_complete[0];
    assign retire_mask[1] = retire_mask[0] & rob_valid[1] & rob_complete[1] & ~stop_after[0];
    assign retire_mask[2] = retire_mask[1] & rob_valid[2] & rob_complete[2] & ~stop_after[1];

    assign rob_pop = {1'b0, retire_mask[0]} + {1'b0, retire_mask[1]} + {1'b0, retire_mask[2]};

    always_comb begin
        state_d      = state_q;
        retire_en_d  = '0;
        retire_reg_d = '0;
        arch_map_d   = arch_map_q;
        case (state_q)
            NORMAL: begin
                // Ascending way order lets the youngest writer of a shared AR win.
                for (int i = 0; i < 3; i++) begin
                    if (retire_mask[i] && rob_ar[i] != 5'd0) begin
                        arch_map_d[rob_ar[i]] = rob_t[i];
                        retire_en_d[i]        = 1'b1;
                        retire_reg_d[i]       = rob_told[i];
                    end
                end
                if (|(retire_mask & rob_halt)) begin
                    state_d = HALT;
                end else if (|(retire_mask & rob_mispredict)) begin
                    state_d = RECOVER;
                end
            end
            RECOVER: state_d = NORMAL;
            HALT:    state_d = HALT;
            default: state_d = NORMAL;
        endcase
        if (reset) begin
            state_d      = NORMAL;
            retire_en_d  = '0;
            retire_reg_d = '0;
            for (int i = 0; i < AR_N; i++) begin
                arch_map_d[i] = PR_W'(i);
            end
        end
        bp_recover_d = (state_d == RECOVER);
        halted_d     = (state_d == HALT);
    end

    always_ff @(posedge clock) begin
        state_q      <= state_d;
        retire_en_q  <= retire_en_d;
        retire_reg_q <= retire_reg_d;
        bp_recover_q <= bp_recover_d;
        halted_q     <= halted_d;
        arch_map_q   <= arch_map_d;
    end

    assign RetireEN    = retire_en_q;
    assign RetireReg   = retire_reg_q;
    assign BPRecoverEN = bp_recover_q;
    assign halted      = halted_q;
    assign arch_map    = arch_map_q;

endmodule
